// File: rtl/fir_ma_pkg.sv
// Shared width derivations, rounding constant and legal parameter limits
// for the multi-channel moving-average filter.
package fir_ma_pkg;

  localparam int LOG2_TAPS_MIN = 1;
  localparam int LOG2_TAPS_MAX = 8;
  localparam int CHANNELS_MIN  = 1;
  localparam int CHANNELS_MAX  = 16;

  // The running sum needs LOG2_TAPS guard bits above the sample width.
  function automatic int acc_w(input int data_w, input int log2_taps);
    return data_w + log2_taps;
  endfunction

  function automatic int ch_w(input int channels);
    return (channels > 1) ? $clog2(channels) : 1;
  endfunction

  // Half an LSB of the scaled result when rounding; zero gives floor.
  function automatic int rnd_const(input int log2_taps, input int round_en);
    return (round_en != 0) ? (1 << (log2_taps - 1)) : 0;
  endfunction

endpackage

// File: rtl/ma_delay_line.sv
// Per-channel circular sample buffer: returns the oldest sample of the
// addressed channel combinationally and overwrites it on the same edge.
module ma_delay_line
  import fir_ma_pkg::*;
#(
  parameter  int DATA_W    = 16,
  parameter  int LOG2_TAPS = 3,
  parameter  int CHANNELS  = 1,
  localparam int CH_W      = ch_w(CHANNELS)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     wr_en,
  input  logic [CH_W-1:0]          ch,
  input  logic signed [DATA_W-1:0] wr_data,
  output logic signed [DATA_W-1:0] rd_data
);

  localparam int TAPS = 1 << LOG2_TAPS;

  logic signed [DATA_W-1:0] line_mem [CHANNELS][TAPS];
  logic [LOG2_TAPS-1:0]     wp       [CHANNELS];

  // Slot at wp is the oldest sample; it is read before being overwritten.
  assign rd_data = line_mem[ch][wp[ch]];

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      for (int c = 0; c < CHANNELS; c++) begin
        wp[c] <= '0;
        for (int t = 0; t < TAPS; t++) begin
          line_mem[c][t] <= '0;
        end
      end
    end else if (wr_en) begin
      line_mem[ch][wp[ch]] <= wr_data;
      wp[ch]               <= wp[ch] + 1'b1;
    end
  end

endmodule

// File: rtl/fir_ma_filter_mc.sv
// Time-multiplexed running-sum moving-average filter: one add and one
// subtract per accepted sample, per-channel accumulators and fill counters.
module fir_ma_filter_mc
  import fir_ma_pkg::*;
#(
  parameter  int DATA_W    = 16,
  parameter  int LOG2_TAPS = 3,
  parameter  int CHANNELS  = 1,
  parameter  int ROUND     = 0,
  localparam int CH_W      = ch_w(CHANNELS)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     in_valid,
  input  logic [CH_W-1:0]          in_ch,
  input  logic signed [DATA_W-1:0] d,
  output logic                     out_valid,
  output logic [CH_W-1:0]          out_ch,
  output logic signed [DATA_W-1:0] q,
  output logic [CHANNELS-1:0]      primed,
  output logic                     ch_err
);

  localparam int ACC_W   = acc_w(DATA_W, LOG2_TAPS);
  localparam int TAPS    = 1 << LOG2_TAPS;
  localparam int FILL_W  = LOG2_TAPS + 1;
  localparam int CH_SPAN = 1 << CH_W;
  localparam logic signed [ACC_W-1:0] RND       = ACC_W'(rnd_const(LOG2_TAPS, ROUND));
  localparam logic [FILL_W-1:0]       FILL_FULL = FILL_W'(TAPS);

  if (LOG2_TAPS < LOG2_TAPS_MIN || LOG2_TAPS > LOG2_TAPS_MAX ||
      CHANNELS < CHANNELS_MIN || CHANNELS > CHANNELS_MAX) begin : g_param_check
    $error("fir_ma_filter_mc: parameter out of legal range");
  end

  function automatic logic [CH_SPAN-1:0] legal_mask();
    logic [CH_SPAN-1:0] m;
    m = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      m[i] = 1'b1;
    end
    return m;
  endfunction

  localparam logic [CH_SPAN-1:0] CH_LEGAL = legal_mask();

  // Sum never overflows ACC_W and the scaled result always fits DATA_W,
  // so no saturation stage is required.
  function automatic logic signed [DATA_W-1:0] scale_avg(input logic signed [ACC_W-1:0] sum);
    logic signed [ACC_W-1:0] biased;
    logic signed [ACC_W-1:0] shifted;
    biased  = sum + RND;
    shifted = biased >>> LOG2_TAPS;
    return shifted[DATA_W-1:0];
  endfunction

  logic                     flush;
  logic                     ch_ok;
  logic                     accept;
  logic                     bad_ch;
  logic [CH_W-1:0]          ch_sel;
  logic signed [DATA_W-1:0] old_sample;
  logic signed [ACC_W-1:0]  acc      [CHANNELS];
  logic [FILL_W-1:0]        fill     [CHANNELS];
  logic signed [ACC_W-1:0]  acc_cur;
  logic signed [ACC_W-1:0]  d_ext;
  logic signed [ACC_W-1:0]  old_ext;
  logic signed [ACC_W-1:0]  acc_new;

  assign flush  = reset | clear;
  assign ch_ok  = CH_LEGAL[in_ch];
  assign accept = in_valid & ch_ok & ~flush;
  assign bad_ch = in_valid & ~ch_ok & ~flush;
  // Illegal indices never reach the arrays; they are steered to channel 0.
  assign ch_sel = ch_ok ? in_ch : '0;

  ma_delay_line #(
    .DATA_W    (DATA_W),
    .LOG2_TAPS (LOG2_TAPS),
    .CHANNELS  (CHANNELS)
  ) u_line (
    .clk     (clk),
    .reset   (reset),
    .clear   (clear),
    .wr_en   (accept),
    .ch      (ch_sel),
    .wr_data (d),
    .rd_data (old_sample)
  );

  assign acc_cur = acc[ch_sel];
  assign d_ext   = {{LOG2_TAPS{d[DATA_W-1]}}, d};
  assign old_ext = {{LOG2_TAPS{old_sample[DATA_W-1]}}, old_sample};
  assign acc_new = acc_cur + d_ext - old_ext;

  always_ff @(posedge clk) begin
    if (flush) begin
      for (int c = 0; c < CHANNELS; c++) begin
        acc[c]  <= '0;
        fill[c] <= '0;
      end
    end else if (accept) begin
      acc[ch_sel] <= acc_new;
      if (fill[ch_sel] != FILL_FULL) begin
        fill[ch_sel] <= fill[ch_sel] + 1'b1;
      end
    end
  end

  always_comb begin
    primed = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      primed[c] = (fill[c] == FILL_FULL);
    end
  end

  // Stage p0: registered average, one cycle after the accept.
  logic                     vld_p0;
  logic [CH_W-1:0]          ch_p0;
  logic signed [DATA_W-1:0] q_p0;
  logic                     err_p0;

  always_ff @(posedge clk) begin
    if (flush) begin
      vld_p0 <= 1'b0;
      ch_p0  <= '0;
      q_p0   <= '0;
      err_p0 <= 1'b0;
    end else begin
      vld_p0 <= accept;
      if (accept) begin
        ch_p0 <= in_ch;
        q_p0  <= scale_avg(acc_new);
      end
      if (bad_ch) begin
        err_p0 <= 1'b1;
      end
    end
  end

  assign out_valid = vld_p0;
  assign out_ch    = ch_p0;
  assign q         = q_p0;
  assign ch_err    = err_p0;

endmodule

// File: tb/tb_fir_ma_filter_mc.sv
// Directed bench: a history-based reference model checked every cycle,
// plus literal expectations for the step, impulse, rounding and channel cases.
module tb_fir_ma_filter_mc;

  logic               clk = 1'b0;
  logic               reset = 1'b0;
  logic               clear = 1'b0;
  logic               in_valid = 1'b0;
  logic [1:0]         in_ch = '0;
  logic signed [15:0] d = '0;
  logic               out_valid;
  logic [1:0]         out_ch;
  logic signed [15:0] q;
  logic [2:0]         primed;
  logic               ch_err;

  logic               in_valid_r;
  logic [0:0]         in_ch_r = 1'b0;
  logic               out_valid_r;
  logic [0:0]         out_ch_r;
  logic signed [15:0] q_r;
  logic [0:0]         primed_r;
  logic               ch_err_r;

  always #5 clk = ~clk;

  fir_ma_filter_mc #(.DATA_W(16), .LOG2_TAPS(3), .CHANNELS(3), .ROUND(0)) dut (
    .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .in_ch(in_ch), .d(d),
    .out_valid(out_valid), .out_ch(out_ch), .q(q), .primed(primed), .ch_err(ch_err));

  // Rounding instance sees only the channel-0 traffic.
  assign in_valid_r = in_valid && (in_ch == 2'd0);

  fir_ma_filter_mc #(.DATA_W(16), .LOG2_TAPS(3), .CHANNELS(1), .ROUND(1)) dut_r (
    .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid_r), .in_ch(in_ch_r), .d(d),
    .out_valid(out_valid_r), .out_ch(out_ch_r), .q(q_r), .primed(primed_r), .ch_err(ch_err_r));

  int n_vec = 0;
  int n_bad = 0;
  bit armed = 1'b0;

  // Reference: full sample history since the last flush.
  int sh_ch[$];
  int sh_d[$];
  int exp_valid = 0, exp_ch = 0, exp_q = 0, exp_err = 0;
  int exp_valid_r = 0, exp_q_r = 0;

  function automatic int floor_div8(input int s);
    int r;
    r = s / 8;
    if ((s % 8) != 0 && s < 0) r = r - 1;
    return r;
  endfunction

  function automatic int win_sum(input int c);
    int s = 0;
    int n = 0;
    for (int i = sh_ch.size() - 1; i >= 0 && n < 8; i--) begin
      if (sh_ch[i] == c) begin
        s += sh_d[i];
        n++;
      end
    end
    return s;
  endfunction

  function automatic int exp_primed(input int nch);
    int p = 0;
    for (int c = 0; c < nch; c++) begin
      int n = 0;
      foreach (sh_ch[i]) if (sh_ch[i] == c) n++;
      if (n >= 8) p |= (1 << c);
    end
    return p;
  endfunction

  function automatic void model_step(input int v, input int ch, input int dd, input bit flush);
    if (flush) begin
      sh_ch.delete();
      sh_d.delete();
      exp_valid = 0; exp_ch = 0; exp_q = 0; exp_err = 0;
      exp_valid_r = 0; exp_q_r = 0;
    end else if (v != 0 && ch < 3) begin
      sh_ch.push_back(ch);
      sh_d.push_back(dd);
      exp_valid = 1;
      exp_ch = ch;
      exp_q = floor_div8(win_sum(ch));
      if (ch == 0) begin
        exp_valid_r = 1;
        exp_q_r = floor_div8(win_sum(0) + 4);
      end else begin
        exp_valid_r = 0;
      end
    end else begin
      exp_valid = 0;
      exp_valid_r = 0;
      if (v != 0) exp_err = 1;
    end
  endfunction

  task automatic check(input string name, input int act, input int req);
    n_vec++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    if (armed) begin
      check("out_valid", int'(out_valid), exp_valid);
      check("out_ch", int'(out_ch), exp_ch);
      check("q", int'(q), exp_q);
      check("primed", int'(primed), exp_primed(3));
      check("ch_err", int'(ch_err), exp_err);
      check("out_valid_r", int'(out_valid_r), exp_valid_r);
      check("q_r", int'(q_r), exp_q_r);
      check("primed_r", int'(primed_r), exp_primed(1) & 1);
    end
  end

  task automatic send(input int v, input int ch, input int dd, input bit clr, input bit rst);
    logic [31:0] dv;
    dv = dd;
    in_valid = v[0];
    in_ch = ch[1:0];
    d = dv[15:0];
    clear = clr;
    reset = rst;
    @(posedge clk);
    #1;
    model_step(v, ch, dd, clr | rst);
    armed = 1'b1;
  endtask

  task automatic idle();
    send(0, 0, 0, 1'b0, 1'b0);
  endtask

  task automatic do_clear();
    send(0, 0, 0, 1'b1, 1'b0);
  endtask

  int step_exp[10] = '{4095, 8191, 12287, 16383, 20479, 24575, 28671, 32767, 32767, 32767};

  initial begin
    send(0, 0, 0, 1'b0, 1'b1);
    send(0, 0, 0, 1'b0, 1'b1);
    check("rst_q", int'(q), 0);
    check("rst_valid", int'(out_valid), 0);
    check("rst_primed", int'(primed), 0);
    check("rst_err", int'(ch_err), 0);

    // Step response
    for (int k = 0; k < 10; k++) begin
      send(1, 0, 32'h7FFF, 1'b0, 1'b0);
      check("step_q", int'(q), step_exp[k]);
      if (k == 6) check("step_primed7", int'(primed[0]), 0);
      if (k == 7) check("step_primed8", int'(primed[0]), 1);
    end

    // Impulse
    do_clear();
    send(1, 0, 32'h7FFF, 1'b0, 1'b0);
    check("imp_q0", int'(q), 4095);
    for (int k = 1; k < 10; k++) begin
      send(1, 0, 0, 1'b0, 1'b0);
      check("imp_q", int'(q), (k < 8) ? 4095 : 0);
    end

    // Negative full scale
    do_clear();
    for (int k = 1; k <= 8; k++) begin
      send(1, 0, -32768, 1'b0, 1'b0);
      check("neg_q", int'(q), -4096 * k);
    end

    // Lone -1: floor versus round-half-up
    do_clear();
    send(1, 0, -1, 1'b0, 1'b0);
    check("m1_trunc", int'(q), -1);
    check("m1_round", int'(q_r), 0);

    // Interleaved channels, back to back
    do_clear();
    for (int k = 1; k <= 8; k++) begin
      send(1, 0, 800, 1'b0, 1'b0);
      check("il_q0", int'(q), 100 * k);
      check("il_ch0", int'(out_ch), 0);
      send(1, 1, -800, 1'b0, 1'b0);
      check("il_q1", int'(q), -100 * k);
      check("il_ch1", int'(out_ch), 1);
    end
    check("il_primed", int'(primed), 3);

    // clear together with a sample
    do_clear();
    for (int k = 0; k < 5; k++) send(1, 0, 800, 1'b0, 1'b0);
    check("clr_pre_q", int'(q), 500);
    send(1, 0, 800, 1'b1, 1'b0);
    check("clr_valid", int'(out_valid), 0);
    check("clr_q", int'(q), 0);
    check("clr_primed", int'(primed), 0);
    send(1, 0, 800, 1'b0, 1'b0);
    check("clr_post_q", int'(q), 100);

    // Bad channel
    do_clear();
    for (int k = 0; k < 3; k++) send(1, 0, 800, 1'b0, 1'b0);
    for (int k = 0; k < 2; k++) send(1, 1, -800, 1'b0, 1'b0);
    send(1, 3, 12345, 1'b0, 1'b0);
    check("bad_valid", int'(out_valid), 0);
    check("bad_err", int'(ch_err), 1);
    idle();
    idle();
    check("bad_err_held", int'(ch_err), 1);
    send(1, 0, 800, 1'b0, 1'b0);
    check("bad_q0", int'(q), 400);
    send(1, 1, -800, 1'b0, 1'b0);
    check("bad_q1", int'(q), -300);
    do_clear();
    check("bad_err_clr", int'(ch_err), 0);

    // Reset in the same cycle as a sample
    send(1, 0, 800, 1'b0, 1'b0);
    send(1, 0, 800, 1'b0, 1'b1);
    check("rst_mid_valid", int'(out_valid), 0);
    check("rst_mid_q", int'(q), 0);
    idle();
    idle();

    armed = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/fir_ma_filter_mc.md
Name: fir_ma_filter_mc

Overview:
Parametrised, multi-channel moving-average FIR filter. It is the successor to the fixed 8-tap, 16-bit, single-channel MA filter.
- Uses a running-sum architecture: one add and one subtract per accepted sample, independent of tap count.
- Channels are time-multiplexed through a single datapath, with a per-channel delay line and accumulator.
- Sits between sample sources (ADC/ROM stimulus) and downstream DSP.
- Input is a valid-qualified stream with no backpressure.

Parameters:
- DATA_W, 16, signed sample width in and out.
- LOG2_TAPS, 3, taps = 2**LOG2_TAPS; legal range 1..8.
- CHANNELS, 1, number of interleaved channels; legal range 1..16.
- ROUND, 0, 0 = truncate (arithmetic shift, floor); 1 = round half up (add 2**(LOG2_TAPS-1) before shift).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- clear  in  1  synchronous flush of all channel state; same effect as reset on the datapath.
- in_valid  in  1  d/in_ch qualify this cycle.
- in_ch  in  CH_W  channel index; CH_W = max(1, $clog2(CHANNELS)).
- d  in  DATA_W  signed sample.
- out_valid  out  1  q/out_ch valid, one-cycle pulse per accepted sample.
- out_ch  out  CH_W  channel of q.
- q  out  DATA_W  signed moving average.
- primed  out  CHANNELS  bit c = 1 once channel c has received at least TAPS samples since last reset/clear.
- ch_err  out  1  sticky: an in_ch >= CHANNELS was presented with in_valid.

Behaviour:

Reset (reset=1):
- All outputs are 0.
- All delay-line entries, accumulators, write pointers and fill counters are 0.

Accept (in_valid=1, in_ch=c < CHANNELS, no reset/clear):
- old = line[c][wp[c]].
- acc[c] <= acc[c] + d - old.
- line[c][wp[c]] <= d.
- wp[c] <= wp[c]+1 mod TAPS, wrapping naturally at TAPS-1 -> 0.

Widths and arithmetic:
- Accumulator width ACC_W = DATA_W + LOG2_TAPS, signed; all arithmetic is sign-extended to ACC_W.
- The new sum never overflows ACC_W.

Output:
- Latency is 1 cycle: the cycle after an accept, out_valid=1, out_ch=c, q = (acc_new [+ rnd]) >>> LOG2_TAPS.
- q always fits DATA_W; no saturation logic is needed. With ROUND=1, the max is (TAPS*(2**(DATA_W-1)-1) + TAPS/2) >> L, which still equals max positive.
- out_valid=0 on any cycle without an accept; q and out_ch hold their last values.

Priming:
- Before priming, empty slots contribute 0. The output is therefore the ramp sum/TAPS, not the average of the samples received so far.
- fill[c] counts up to TAPS and saturates; primed[c] = (fill[c]==TAPS).

Back-to-back operation:
- in_valid may be high every cycle, including the same channel on consecutive cycles.
- Same-channel consecutive samples must use the updated acc/wp with no bubble. Either forward, or keep acc/wp in flops; delay-line read must not be stale.

Invalid channel:
- in_valid=1 with in_ch >= CHANNELS: sample discarded, no state change, no out_valid, ch_err <= 1.
- ch_err clears only on reset or clear.

clear:
- Same cycle as in_valid: clear wins and the sample is discarded.
- Next cycle: out_valid=0, primed=0, ch_err=0, accumulators/lines/pointers/fill=0.
- q and out_ch are reset to 0.

Mid-operation reset: same as clear; any pending output is not emitted.

Decomposition:

Package fir_ma_pkg:
- ACC_W and CH_W derivation functions.
- Rounding constant function rnd_const(LOG2_TAPS, ROUND).
- Legal-range limits for LOG2_TAPS/CHANNELS.

Sub-module ma_delay_line:
- Parameters: DATA_W, LOG2_TAPS, CHANNELS.
- Per-channel circular buffer plus write pointers.
- Read-before-write of the oldest sample in the same cycle.
- clear/reset zero all entries.

Top level: accumulators, fill counters, channel decode, output register.

Test Plan:
1. Step response, defaults:
   - Stimulus: reset 2 cycles, then d=0x7FFF every cycle on ch0.
   - Required: q = 4095, 8191, 12287, 16383, 20479, 24575, 28671, 32767, then 32767 held.
   - primed[0] rises with the 8th output.
2. Impulse:
   - Stimulus: single d=0x7FFF then d=0 continuously.
   - Required: eight outputs of 4095, then 0.
3. Negative values and rounding:
   - Stimulus: d=-32768 constant.
   - Required: q = -4096, -8192, ..., -32768.
   - Stimulus: lone d=-1. Required: q=-1 with ROUND=0; q=0 with ROUND=1.
4. Interleaved channels:
   - Stimulus: CHANNELS=2, alternating ch0 d=800 / ch1 d=-800 every cycle.
   - Required: ch0 q = 100, 200, ..., 800.
   - Required: ch1 q = -100, ..., -800.
   - out_ch alternates; there is no cross-talk.
5. clear mid-stream:
   - Stimulus: after 5 samples of 800 on ch0, assert clear together with in_valid.
   - Required: the sample is dropped, primed=0, next sample 800 gives q=100.
6. Bad channel:
   - Stimulus: CHANNELS=3, in_ch=3 with in_valid.
   - Required: no out_valid, ch_err=1, held until clear; existing channel sums are unchanged.
